// File: rtl/tdc_core.sv
// tdc_core: SPAD TDC front end; stamps up to MAX_HITS hits per window, drains them as beats, then pulses TDC_INT.
// Latency: first beat valid two cycles after the last window cycle; beats are held stable while TDC_Oready is low.
module tdc_core #(
  parameter int COARSE_W    = 10,
  parameter int FINE_W      = 5,
  parameter int MAX_HITS    = 3,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [(1<<FINE_W)-1:0]          DLL_Phase,
  input  logic                            TDC_start,
  input  logic                            TDC_trigger,
  input  logic [15:0]                     TDC_spaden,
  input  logic                            TDC_tgate,
  input  logic [COARSE_W+FINE_W-1:0]      TDC_Range,
  output logic [COARSE_W+FINE_W-1:0]      TDC_Odata,
  output logic [3:0]                      TDC_Oint,
  output logic [$clog2(MAX_HITS+1)-1:0]   TDC_Onum,
  output logic                            TDC_Olast,
  output logic                            TDC_Ovalid,
  input  logic                            TDC_Oready,
  output logic                            TDC_INT,
  output logic                            rst_auto
);

  localparam int TS_W   = COARSE_W + FINE_W;
  localparam int NUM_W  = $clog2(MAX_HITS + 1);
  localparam int PH_N   = 1 << FINE_W;
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, OUTPUT} state_t;

  state_t              state;
  logic                start_q;
  logic                trig_q;
  logic [COARSE_W-1:0] coarse;
  logic [NUM_W-1:0]    hit_cnt;
  logic [NUM_W-1:0]    beat_idx;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [TS_W-1:0]     hit_ts  [MAX_HITS];
  logic [3:0]          hit_int [MAX_HITS];

  logic [FINE_W-1:0]   fine_code;
  logic [4:0]          ones;
  logic [3:0]          int_sat;
  logic [COARSE_W-1:0] limit;
  logic                start_rise;
  logic                accept;
  logic [NUM_W-1:0]    nxt;
  logic                ld_last;
  logic                unused_range;

  assign limit        = TDC_Range[TS_W-1:FINE_W];
  assign unused_range = ^TDC_Range[FINE_W-1:0];
  assign start_rise   = TDC_start & ~start_q;
  assign accept       = (state == MEASURE) && TDC_trigger && !trig_q && TDC_tgate &&
                        !rst_auto && (hit_cnt < NUM_W'(MAX_HITS));

  // Fine code is the lowest bit where the rotating run of ones begins.
  always_comb begin
    fine_code = '0;
    for (int i = PH_N - 1; i >= 0; i--) begin
      if (DLL_Phase[i] && !DLL_Phase[(i + PH_N - 1) % PH_N]) fine_code = FINE_W'(i);
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 16; i++) ones = ones + 5'(TDC_spaden[i]);
    int_sat = ones[4] ? 4'hF : ones[3:0];
  end

  assign nxt     = TDC_Ovalid ? beat_idx + NUM_W'(1) : '0;
  assign ld_last = (hit_cnt == '0) || (nxt == hit_cnt - NUM_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      trig_q     <= 1'b0;
      coarse     <= '0;
      hit_cnt    <= '0;
      beat_idx   <= '0;
      dead_cnt   <= '0;
      rst_auto   <= 1'b0;
      TDC_Odata  <= '0;
      TDC_Oint   <= '0;
      TDC_Onum   <= '0;
      TDC_Olast  <= 1'b0;
      TDC_Ovalid <= 1'b0;
      TDC_INT    <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        hit_ts[i]  <= '0;
        hit_int[i] <= '0;
      end
    end else begin
      start_q <= TDC_start;
      trig_q  <= TDC_trigger;
      TDC_INT <= 1'b0;

      // Dead time runs independently of the window so a closing window never cuts it short.
      if (accept) begin
        rst_auto <= 1'b1;
        dead_cnt <= DEAD_W'(DEAD_CYCLES - 1);
      end else if (dead_cnt != '0) begin
        dead_cnt <= dead_cnt - DEAD_W'(1);
      end else begin
        rst_auto <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_rise) begin
            state   <= MEASURE;
            coarse  <= '0;
            hit_cnt <= '0;
          end
        end
        MEASURE: begin
          if (accept) begin
            hit_ts[hit_cnt]  <= {coarse, fine_code};
            hit_int[hit_cnt] <= int_sat;
            hit_cnt          <= hit_cnt + NUM_W'(1);
          end
          if (coarse == limit) begin
            state    <= OUTPUT;
            beat_idx <= '0;
          end else begin
            coarse <= coarse + COARSE_W'(1);
          end
        end
        OUTPUT: begin
          if (TDC_Ovalid && TDC_Oready && TDC_Olast) begin
            TDC_Ovalid <= 1'b0;
            TDC_Olast  <= 1'b0;
            TDC_Odata  <= '0;
            TDC_Oint   <= '0;
            TDC_Onum   <= '0;
            TDC_INT    <= 1'b1;
            state      <= IDLE;
          end else if (!TDC_Ovalid || TDC_Oready) begin
            // An empty window still produces one all-ones marker beat.
            beat_idx   <= nxt;
            TDC_Ovalid <= 1'b1;
            TDC_Odata  <= (hit_cnt == '0) ? '1 : hit_ts[nxt];
            TDC_Oint   <= (hit_cnt == '0) ? '0 : hit_int[nxt];
            TDC_Onum   <= hit_cnt;
            TDC_Olast  <= ld_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_core.sv
// Scoreboard bench for tdc_core: stimulus predicts beats from window rules into a queue; a monitor pops and compares.
module tb_tdc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DLL_Phase;
  logic        TDC_start, TDC_trigger, TDC_tgate, TDC_Oready;
  logic [15:0] TDC_spaden;
  logic [14:0] TDC_Range;
  logic [14:0] TDC_Odata;
  logic [3:0]  TDC_Oint;
  logic [1:0]  TDC_Onum;
  logic        TDC_Olast, TDC_Ovalid, TDC_INT, rst_auto;

  always #5 clk = ~clk;

  tdc_core dut (
    .clk(clk), .rst(rst), .DLL_Phase(DLL_Phase), .TDC_start(TDC_start),
    .TDC_trigger(TDC_trigger), .TDC_spaden(TDC_spaden), .TDC_tgate(TDC_tgate),
    .TDC_Range(TDC_Range), .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint),
    .TDC_Onum(TDC_Onum), .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid),
    .TDC_Oready(TDC_Oready), .TDC_INT(TDC_INT), .rst_auto(rst_auto)
  );

  typedef struct {
    logic [14:0] d;
    logic [3:0]  i;
    logic [1:0]  n;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0, miscompares = 0;
  int    edge_cnt = 0;
  int    last_acc = -100;
  int    int_due = -100;
  int    wins_done = 0;
  int    hold_low = 0;
  bit    chk_on = 0;
  bit    rnd_ready = 0;
  bit    use_dir = 1;
  int    fix_rot = -1;
  int    dir_k[$];
  logic [15:0] dir_en[$];

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  // Monitor: dead-time window, interrupt timing, beat contents and stability under backpressure.
  initial begin
    bit    held = 0;
    logic [22:0] held_val = '0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("rst_auto", {31'd0, rst_auto},
            {31'd0, (edge_cnt - last_acc) >= 0 && (edge_cnt - last_acc) <= 3});
        chk("int_pulse", {31'd0, TDC_INT}, {31'd0, edge_cnt == int_due});
        if (TDC_INT) wins_done++;
        if (held) chk("hold_stable", {9'd0, TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast},
                      {9'd0, held_val});
        if (TDC_Ovalid) begin
          if (TDC_Oready) begin
            held = 0;
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_beat: got %h with no beat expected",
                       {TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast});
            end else begin
              b = exp_q.pop_front();
              chk("beat", {10'd0, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast},
                  {10'd0, b.d, b.i, b.n, b.l});
              if (b.l) int_due = edge_cnt + 1;
            end
          end else begin
            held = 1;
            held_val = {1'b1, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast};
          end
        end else begin
          held = 0;
          chk("idle_zero", {10'd0, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast}, 32'd0);
        end
      end
    end
  end

  initial begin
    TDC_Oready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low > 0) begin
        TDC_Oready = 1'b0;
        hold_low--;
      end else begin
        TDC_Oready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // One window: a start edge, then limit+1 samples with coarse equal to the sample index.
  task automatic run_window(input int limit, input int abort_k, input int bp);
    int          n = 0, di = 0, e, r, fine, cnt, target;
    bit          prev = 0, trig, acc;
    logic [14:0] ts[3];
    logic [3:0]  it[3];
    beat_t       b;
    target = wins_done + 1;
    @(posedge clk); #1;
    TDC_Range = {10'(limit), 5'($urandom)};
    TDC_start = 1'b1;
    TDC_trigger = 1'b0;
    for (int k = 0; k <= limit; k++) begin
      @(posedge clk); #1;
      TDC_start = 1'b0;
      if (k == abort_k) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      e = edge_cnt + 1;
      if (use_dir) begin
        trig = (di < dir_k.size()) && (dir_k[di] == k);
        TDC_tgate = 1'b1;
        TDC_spaden = trig ? dir_en[di] : 16'($urandom);
        if (trig) di++;
      end else begin
        trig = ($urandom_range(0, 2) == 0);
        TDC_tgate = ($urandom_range(0, 3) != 0);
        TDC_spaden = 16'($urandom);
      end
      TDC_trigger = trig;
      r = (fix_rot >= 0) ? fix_rot : $urandom_range(0, 33);
      if (r < 32) begin
        DLL_Phase = rotl(32'h0000FFFF, r);
        fine = r;
      end else begin
        DLL_Phase = (r == 32) ? 32'h0 : 32'hFFFFFFFF;
        fine = 0;
      end
      acc = trig && !prev && TDC_tgate && !((e - last_acc) >= 1 && (e - last_acc) <= 4) && (n < 3);
      prev = trig;
      if (acc) begin
        cnt = $countones(TDC_spaden);
        ts[n] = {10'(k), 5'(fine)};
        it[n] = (cnt > 15) ? 4'd15 : 4'(cnt);
        n++;
        last_acc = e;
      end
    end
    if (n == 0) begin
      b.d = 15'h7FFF; b.i = 4'd0; b.n = 2'd0; b.l = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int j = 0; j < n; j++) begin
        b.d = ts[j]; b.i = it[j]; b.n = 2'(n); b.l = (j == n - 1);
        exp_q.push_back(b);
      end
    end
    if (bp != 0) hold_low = 8;
    @(posedge clk); #1;
    TDC_trigger = 1'b0;
    TDC_tgate = 1'b0;
    for (int c = 0; c < 3000 && wins_done < target; c++) @(posedge clk);
    chk("window_drained", {31'd0, wins_done >= target}, 32'd1);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    DLL_Phase = 32'h0;
    TDC_start = 1'b0;
    TDC_trigger = 1'b0;
    TDC_tgate = 1'b0;
    TDC_spaden = 16'h0;
    TDC_Range = 15'h0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {13'd0, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, TDC_INT, rst_auto},
        32'd0);
    chk_on = 1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    fix_rot = 16;
    dir_k = '{5};                                dir_en = '{16'h000F};
    run_window(31, -1, 0);
    fix_rot = -1;
    dir_k = '{2, 10, 20, 30};                    dir_en = '{16'h00FF, 16'h0FFF, 16'hFFFF, 16'hFFFF};
    run_window(40, -1, 0);
    dir_k = '{3, 5};                             dir_en = '{16'h0101, 16'h0003};
    run_window(12, -1, 0);
    dir_k = '{1, 8, 16};                         dir_en = '{16'h0001, 16'h0033, 16'h7777};
    run_window(20, -1, 1);
    dir_k.delete();                              dir_en.delete();
    run_window(7, -1, 0);
    dir_k = '{0};                                dir_en = '{16'h8000};
    run_window(0, -1, 0);
    repeat (6) @(posedge clk);
    dir_k.delete();                              dir_en.delete();
    run_window(20, 6, 0);
    repeat (12) @(posedge clk);

    use_dir = 0;
    rnd_ready = 1;
    for (int w = 0; w < 40; w++) run_window($urandom_range(0, 40), -1, 0);
    repeat (10) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdc_core.md
Name: tdc_core

Overview:
- Single-clock time-to-digital converter front end.
- TDC_start opens a measurement window. SPAD triggers inside the window are timestamped as coarse cycle count plus fine DLL phase, with intensity taken from the SPAD enable mask.
- Up to 3 hits are stored per window and drained over an AXI-stream-like output when the window closes, followed by an interrupt pulse.
- Also drives rst_auto, the dead-time reset back to the SPAD pixel.

Parameters:
- COARSE_W, 10, coarse counter width.
- FINE_W, 5, fine code width (log2 of 32 DLL phases).
- MAX_HITS, 3, hits stored per window.
- DEAD_CYCLES, 4, rst_auto high time in clk cycles after each accepted hit.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- DLL_Phase  in  32  DLL phase snapshot: contiguous run of 16 ones rotating.
- TDC_start  in  1  start request from core logic.
- TDC_trigger  in  1  SPAD trigger.
- TDC_spaden  in  16  enabled/fired SPAD mask, 4x4.
- TDC_tgate  in  1  time-gate qualifier from analog front end.
- TDC_Range  in  15  window length; coarse limit = TDC_Range[14:5].
- TDC_Odata  out  15  timestamp {coarse[9:0], fine[4:0]}.
- TDC_Oint  out  4  intensity of the current beat.
- TDC_Onum  out  2  number of valid hits in this window.
- TDC_Olast  out  1  last beat of the window.
- TDC_Ovalid  out  1  output beat valid.
- TDC_Oready  in  1  downstream ready.
- TDC_INT  out  1  one-cycle pulse when a window's output is fully drained.
- rst_auto  out  1  SPAD dead-time reset.

Behaviour:
- Reset: state IDLE; all outputs 0; coarse counter, hit count and dead-time counter cleared; stored hits discarded. A reset mid-window or mid-drain aborts immediately with no TDC_INT.
- States: IDLE -> MEASURE -> OUTPUT -> IDLE.
- IDLE -> MEASURE: on rising edge of TDC_start (sampled start=1, previous sample=0). Coarse cleared to 0 and hit count to 0 on entry.
- TDC_start edges outside IDLE are ignored.
- MEASURE:
  - Coarse increments by 1 every cycle.
  - When coarse == TDC_Range[14:5], go to OUTPUT the next cycle; coarse does not wrap.
  - Range limit 0 gives a single-cycle window.
- Hit acceptance, all required in the same cycle:
  - state MEASURE;
  - TDC_trigger rising edge (trigger=1, previous sample=0);
  - TDC_tgate=1;
  - rst_auto=0;
  - hit count < MAX_HITS.
  - Hits failing any condition are dropped silently.
- On an accepted hit, store:
  - {coarse, fine} for that cycle;
  - Oint = popcount(TDC_spaden), saturating at 15 (16 ones -> 15).
- Fine code: smallest i in 0..31 with DLL_Phase[i]=1 and DLL_Phase[(i+31)%32]=0 (run start). No such i (all 0 or all 1) -> fine = 0.
- rst_auto:
  - Goes high the cycle after an accepted hit and stays high exactly DEAD_CYCLES cycles, then falls.
  - Never asserted otherwise.
  - A window ending during dead time does not truncate it.
- OUTPUT with N>0 hits:
  - Beats present hits in capture order; TDC_Onum = N on every beat; TDC_Olast=1 on beat N only.
  - TDC_Ovalid asserts the cycle after entering OUTPUT.
  - Data is held stable while Ovalid=1 and Oready=0.
  - A beat completes on Ovalid & Oready; with Oready held high, one beat per cycle.
- OUTPUT with N=0: a single beat with Odata=15'h7FFF, Oint=0, Onum=0, Olast=1.
- After the last handshake:
  - Ovalid/Olast drop next cycle;
  - TDC_INT=1 for exactly that one cycle;
  - state returns to IDLE; a new TDC_start edge is accepted from the following cycle.
- Outputs are registered; all outputs are 0 when not presenting a beat.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst 2 cycles.
  - Response: all outputs 0; TDC_start held 0 keeps IDLE, no Ovalid.
- Single hit:
  - Stimulus: Range=15'b00000_11111_11100 (limit 31), start edge, trigger+tgate at coarse=5, DLL_Phase=32'hFFFF0000, spaden=16'h000F, Oready=1.
  - Response: one beat Odata={10'd5,5'd16}, Oint=4, Onum=1, Olast=1; TDC_INT pulses one cycle after the handshake.
  - Response: rst_auto high 4 cycles starting the cycle after the hit.
- Hit limit:
  - Stimulus: four spaced hits with spaden 8'hFF, 12'hFFF, 16'hFFFF, 16'hFFFF.
  - Response: 3 beats, Oint 8, 12, 15, Onum=3, Olast on beat 3; fourth hit dropped.
- Dead-time masking:
  - Stimulus: second trigger edge while rst_auto=1.
  - Response: ignored, Onum=1.
- Backpressure:
  - Stimulus: Oready=0 for 5 cycles during drain.
  - Response: Ovalid and data held; no beat lost; TDC_INT only after the last handshake.
- Empty window / abort:
  - Stimulus: no triggers.
  - Response: one beat Odata=7FFF, Onum=0, Olast=1.
  - Stimulus: rst mid-MEASURE.
  - Response: back to IDLE, no output, no TDC_INT.
